mc_control: RTL and testbench

- Multi-cycle control FSM for the MIPS-subset datapath: sequences fetch, decode, execute, memory and writeback over a shared ALU and a single instruction/data memory port.
- Replaces the single-cycle opcode lookup. Drives every datapath enable and mux select.
- Handshakes with a variable-latency memory.

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_alu_dec.sv | 13 +
 rtl/mc_control.sv | 162 ++++++++++++++++
 tb/tb_mc_control.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared opcode/funct codes, ALU commands, FSM states and datapath select encodings
package mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;
  localparam logic [1:0] B_RT   = 2'd0;
  localparam logic [1:0] B_FOUR = 2'd1;
  localparam logic [1:0] B_IMM  = 2'd2;
  localparam logic [1:0] B_IMM4 = 2'd3;
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    WB_MEM   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    EXEC_I   = 4'd8,
    WB_I     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JR       = 4'd12,
    HALT     = 4'd13
  } state_t;

  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn, input logic ill);
    case (op)
      OP_LW, OP_SW:     return MEM_ADDR;
      OP_RTYPE:         return ill ? HALT : (fn == FN_JR ? JR : EXEC_R);
      OP_ADDI, OP_XORI: return EXEC_I;
      OP_BEQ, OP_BNE:   return BRANCH;
      OP_J, OP_JAL:     return JUMP;
      default:          return HALT;
    endcase
  endfunction
endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: R-type funct to ALU command, flagging funct codes the datapath cannot execute
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_cntrl,
  output logic       illegal
);
  always_comb begin
    alu_cntrl = funct == FN_SUB ? ALU_SUB : funct == FN_SLT ? ALU_SLT : ALU_ADD;
    illegal   = !(funct inside {FN_ADD, FN_SUB, FN_SLT, FN_JR});
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS-subset control FSM with variable-latency memory handshake.
// Define MC_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_control
  import mc_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SRC = 2'd0,
  parameter int         MEM_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_cntrl,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       halted,
  output logic [3:0] state_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);
  state_t      state;
  logic [15:0] tcnt;
  logic [2:0]  r_alu;
  logic        f_ill;
  logic        wait_mem;

  mc_alu_dec u_dec (.funct(funct), .alu_cntrl(r_alu), .illegal(f_ill));

  assign wait_mem = mem_req & ~mem_ack;
  assign halted   = state == HALT;
  assign state_o  = state;

  // memory states only reach the case below once mem_ack has arrived
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      tcnt  <= '0;
    end else if (wait_mem && MEM_TIMEOUT != 0 && tcnt == 16'(MEM_TIMEOUT - 1)) begin
      state <= HALT;
      tcnt  <= '0;
    end else if (wait_mem) begin
      tcnt <= tcnt + 16'd1;
    end else begin
      tcnt <= '0;
      case (state)
        FETCH:    state <= DECODE;
        DECODE:   state <= decode_next(opcode, funct, f_ill);
        EXEC_R:   state <= WB_R;
        EXEC_I:   state <= WB_I;
        MEM_ADDR: state <= opcode == OP_LW ? MEM_RD : MEM_WR;
        MEM_RD:   state <= WB_MEM;
        HALT:     state <= HALT;
        WB_R, WB_I, WB_MEM, MEM_WR, BRANCH, JUMP, JR: state <= FETCH;
        default:  state <= HALT;
      endcase
    end
  end

  // reset parks the FSM in FETCH, so only FETCH outputs need gating by rst_n
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = B_RT;
    alu_cntrl  = ALU_ADD;
    reg_we     = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALU;
    case (state)
      FETCH: begin
        mem_req   = rst_n;
        ir_we     = rst_n & mem_ack;
        pc_we     = rst_n & mem_ack;
        pc_src    = rst_n ? PC_ALU : RESET_PC_SRC;
        alu_src_b = rst_n ? B_FOUR : B_RT;
      end
      DECODE: alu_src_b = B_IMM4;
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_cntrl = r_alu;
      end
      WB_R: begin
        reg_we  = 1'b1;
        reg_dst = DST_RD;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = B_IMM;
        alu_cntrl = opcode == OP_XORI ? ALU_XOR : ALU_ADD;
      end
      WB_I: reg_we = 1'b1;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = B_IMM;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = WB_MDR;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_cntrl = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we     = opcode == OP_BNE ? ~zero : zero;
      end
      JUMP: begin
        pc_we      = 1'b1;
        pc_src     = PC_JUMP;
        reg_we     = opcode == OP_JAL;
        reg_dst    = opcode == OP_JAL ? DST_RA : DST_RT;
        mem_to_reg = opcode == OP_JAL ? WB_PC : WB_ALU;
      end
      JR: begin
        pc_we  = 1'b1;
        pc_src = PC_RS;
      end
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic to_fetch;
  assign to_fetch = state inside {WB_R, WB_I, WB_MEM, BRANCH, JUMP, JR} || (state == MEM_WR && mem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (to_fetch) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed scenario bench for mc_control, comparing a packed view of all outputs per cycle
module tb_mc_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, iord, ir_we, pc_we, alu_src_a, reg_we, halted;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_cntrl;
  logic [3:0] state_o;
  logic [22:0] obs;
  logic [22:0] f_ack, f_wait, dec, hv, rstv, ma, mw;
  int checks = 0;
  int failures = 0;

  mc_control #(.RESET_PC_SRC(2'd2), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_cntrl(alu_cntrl), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .halted(halted), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign obs = {state_o, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                alu_cntrl, reg_we, reg_dst, mem_to_reg, halted};

  function automatic logic [22:0] e(int st, int req, int mwe, int io, int irw, int pcw, int pcs,
                                    int a, int b, int alu, int rw, int dst, int m2r, int h);
    return {4'(st), 1'(req), 1'(mwe), 1'(io), 1'(irw), 1'(pcw), 2'(pcs), 1'(a), 2'(b), 3'(alu),
            1'(rw), 2'(dst), 2'(m2r), 1'(h)};
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic tick(input bit ack);
    @(negedge clk);
    mem_ack = ack;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ack = 1'b1;
    #3;
    checks++;
    if (obs !== rstv) begin failures++; $display("FAIL reset obs=%h exp=%h", obs, rstv); end
  endtask

  task automatic test_add();
    logic [22:0] ex[5];
    ex = '{f_ack, dec, e(6,0,0,0,0,0,0,1,0,0,0,0,0,0), e(7,0,0,0,0,0,0,0,0,0,1,1,0,0), f_ack};
    opcode = 6'h00; funct = 6'h20;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      checks++;
      if (obs !== ex[i]) begin failures++; $display("FAIL add cyc%0d obs=%h exp=%h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_rtype_alu();
    logic [5:0] fn[2] = '{6'h22, 6'h2A};
    int alu[2] = '{1, 3};
    logic [22:0] ex[3];
    for (int k = 0; k < 2; k++) begin
      ex = '{f_ack, dec, e(6,0,0,0,0,0,0,1,0,alu[k],0,0,0,0)};
      opcode = 6'h00; funct = fn[k];
      reset_dut();
      for (int i = 0; i < 3; i++) begin
        tick(1'b1);
        checks++;
        if (obs !== ex[i]) begin failures++; $display("FAIL rtype_f%h cyc%0d obs=%h exp=%h", fn[k], i, obs, ex[i]); end
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [22:0] rd;
    logic [22:0] ex[12];
    bit ak[12] = '{0,0,0,1, 1, 1, 0,0,0,1, 0, 0};
    rd = e(3,1,0,1,0,0,0,0,0,0,0,0,0,0);
    ex = '{f_wait, f_wait, f_wait, f_ack, dec, ma, rd, rd, rd, rd, e(4,0,0,0,0,0,0,0,0,0,1,0,1,0), f_wait};
    opcode = 6'h23;
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      tick(ak[i]);
      checks++;
      if (obs !== ex[i]) begin failures++; $display("FAIL lw cyc%0d obs=%h exp=%h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_sw();
    logic [22:0] ex[5];
    ex = '{f_ack, dec, ma, mw, f_wait};
    opcode = 6'h2B;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      tick(i != 4);
      checks++;
      if (obs !== ex[i]) begin failures++; $display("FAIL sw cyc%0d obs=%h exp=%h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_itype();
    logic [5:0] op[2] = '{6'h08, 6'h0E};
    int alu[2] = '{0, 2};
    logic [22:0] ex[5];
    for (int k = 0; k < 2; k++) begin
      ex = '{f_ack, dec, e(8,0,0,0,0,0,0,1,2,alu[k],0,0,0,0), e(9,0,0,0,0,0,0,0,0,0,1,0,0,0), f_wait};
      opcode = op[k];
      reset_dut();
      for (int i = 0; i < 5; i++) begin
        tick(i != 4);
        checks++;
        if (obs !== ex[i]) begin failures++; $display("FAIL itype_op%h cyc%0d obs=%h exp=%h", op[k], i, obs, ex[i]); end
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] op[4] = '{6'h04, 6'h05, 6'h04, 6'h05};
    bit z[4] = '{1, 1, 0, 0};
    int pcw[4] = '{1, 0, 0, 1};
    logic [22:0] ex[4];
    for (int k = 0; k < 4; k++) begin
      ex = '{f_ack, dec, e(10,0,0,0,0,pcw[k],1,1,0,1,0,0,0,0), f_wait};
      opcode = op[k]; zero = z[k];
      reset_dut();
      for (int i = 0; i < 4; i++) begin
        tick(i != 3);
        checks++;
        if (obs !== ex[i]) begin failures++; $display("FAIL branch_op%h_z%0d cyc%0d obs=%h exp=%h", op[k], z[k], i, obs, ex[i]); end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [5:0] op[3] = '{6'h03, 6'h02, 6'h00};
    logic [22:0] jv[3];
    logic [22:0] ex[4];
    jv = '{e(11,0,0,0,0,1,2,0,0,0,1,2,2,0), e(11,0,0,0,0,1,2,0,0,0,0,0,0,0), e(12,0,0,0,0,1,3,0,0,0,0,0,0,0)};
    for (int k = 0; k < 3; k++) begin
      ex = '{f_ack, dec, jv[k], f_wait};
      opcode = op[k]; funct = 6'h08;
      reset_dut();
      for (int i = 0; i < 4; i++) begin
        tick(i != 3);
        checks++;
        if (obs !== ex[i]) begin failures++; $display("FAIL jump_op%h cyc%0d obs=%h exp=%h", op[k], i, obs, ex[i]); end
      end
    end
  endtask

  task automatic test_halt_illegal();
    logic [22:0] ex[8];
    ex = '{f_ack, dec, hv, hv, hv, hv, hv, hv};
    opcode = 6'h3F; funct = 6'h20;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      tick(i < 2 ? 1'b1 : 1'(i % 2));
      checks++;
      if (obs !== ex[i]) begin failures++; $display("FAIL halt_op cyc%0d obs=%h exp=%h", i, obs, ex[i]); end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== rstv) begin failures++; $display("FAIL halt_reset obs=%h exp=%h", obs, rstv); end
    opcode = 6'h00; funct = 6'h21;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      checks++;
      if (obs !== ex[i]) begin failures++; $display("FAIL halt_funct cyc%0d obs=%h exp=%h", i, obs, ex[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [22:0] exp_v;
    opcode = 6'h00; funct = 6'h20;
    reset_dut();
    for (int i = 0; i < 18; i++) begin
      tick(i == 17);
      exp_v = i < 16 ? f_wait : hv;
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL timeout cyc%0d obs=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  task automatic test_async_reset();
    logic [22:0] ex[5];
    ex = '{f_ack, dec, ma, mw, mw};
    opcode = 6'h2B;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      tick(i < 3);
      checks++;
      if (obs !== ex[i]) begin failures++; $display("FAIL async_pre cyc%0d obs=%h exp=%h", i, obs, ex[i]); end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== rstv) begin failures++; $display("FAIL async_drop obs=%h exp=%h", obs, rstv); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1'b1);
    checks++;
    if (obs !== f_ack) begin failures++; $display("FAIL async_fetch obs=%h exp=%h", obs, f_ack); end
    tick(1'b0);
    checks++;
    if (obs !== dec) begin failures++; $display("FAIL async_decode obs=%h exp=%h", obs, dec); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    f_ack  = e(0,1,0,0,1,1,0,0,1,0,0,0,0,0);
    f_wait = e(0,1,0,0,0,0,0,0,1,0,0,0,0,0);
    dec    = e(1,0,0,0,0,0,0,0,3,0,0,0,0,0);
    hv     = e(13,0,0,0,0,0,0,0,0,0,0,0,0,1);
    rstv   = e(0,0,0,0,0,0,2,0,0,0,0,0,0,0);
    ma     = e(2,0,0,0,0,0,0,1,2,0,0,0,0,0);
    mw     = e(5,1,1,1,0,0,0,0,0,0,0,0,0,0);
    test_reset();
    test_add();
    test_rtype_alu();
    test_lw_wait();
    test_sw();
    test_itype();
    test_branch();
    test_jump();
    test_halt_illegal();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
